// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-memory access controller.
// Issues req/ack transactions from EX/MEM, stalls the pipe, formats loads.
module mem_stage_access_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [31:0] inALUResult,
  input  logic [31:0] inReadData2,
  input  logic [31:0] inInstr,
  output logic        MemStall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        AddrError,
  output logic        MemTimeout
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wcnt;

  logic [5:0] opc;
  logic       op_byte;
  logic       op_half;
  logic       op_uns;
  logic [1:0] off;
  logic       access;
  logic       mis;
  logic       tmo;

  logic       l_rd;
  logic       l_byte;
  logic       l_half;
  logic       l_uns;
  logic [1:0] l_off;

  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_fmt;

  logic unused_bits;
  assign unused_bits = ^inInstr[25:0];

  assign opc    = inInstr[31:26];
  assign off    = inALUResult[1:0];
  assign access = inMemRead | inMemWrite;
  assign tmo    = ~MemAck & (wcnt == LAST);

  // Opcode to access size and signedness; unknown opcodes act as words.
  always_comb begin
    op_byte = 1'b0;
    op_half = 1'b0;
    op_uns  = 1'b0;
    case (opc)
      6'h20, 6'h28: op_byte = 1'b1;
      6'h24: begin
        op_byte = 1'b1;
        op_uns  = 1'b1;
      end
      6'h21, 6'h29: op_half = 1'b1;
      6'h25: begin
        op_half = 1'b1;
        op_uns  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mis = (op_half & off[0]) |
               (~op_byte & ~op_half & (off != 2'b00));

  // Store lane replication and byte enables; loads enable every lane.
  always_comb begin
    st_data = inReadData2;
    st_be   = 4'b1111;
    if (inMemWrite) begin
      if (op_byte) begin
        st_data = {4{inReadData2[7:0]}};
        st_be   = 4'b0001 << off;
      end else if (op_half) begin
        st_data = {2{inReadData2[15:0]}};
        st_be   = off[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    ld_b = MemRData[7:0];
    case (l_off)
      2'd1: ld_b = MemRData[15:8];
      2'd2: ld_b = MemRData[23:16];
      2'd3: ld_b = MemRData[31:24];
      default: ;
    endcase
    ld_h   = l_off[1] ? MemRData[31:16] : MemRData[15:0];
    ld_fmt = MemRData;
    if (l_byte)
      ld_fmt = l_uns ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
    else if (l_half)
      ld_fmt = l_uns ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, request and stall.
  always_comb begin
    state_nxt = state;
    MemStall  = 1'b0;
    MemReq    = 1'b0;
    unique case (state)
      IDLE: begin
        if (access && !mis) begin
          MemStall  = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        MemReq   = 1'b1;
        MemStall = 1'b1;
        if (MemAck || tmo) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching, wait counting, load capture and status pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wcnt       <= '0;
      MemWe      <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      MemByteEn  <= '0;
      LoadData   <= '0;
      LoadValid  <= 1'b0;
      AddrError  <= 1'b0;
      MemTimeout <= 1'b0;
      l_rd       <= 1'b0;
      l_byte     <= 1'b0;
      l_half     <= 1'b0;
      l_uns      <= 1'b0;
      l_off      <= '0;
    end else begin
      LoadValid  <= 1'b0;
      MemTimeout <= 1'b0;
      AddrError  <= (state == IDLE) && access && mis;
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (access && !mis) begin
            MemWe     <= inMemWrite;
            MemAddr   <= {inALUResult[31:2], 2'b00};
            MemWData  <= inMemWrite ? st_data : 32'h0;
            MemByteEn <= st_be;
            l_rd      <= ~inMemWrite;
            l_byte    <= op_byte;
            l_half    <= op_half;
            l_uns     <= op_uns;
            l_off     <= off;
          end
        end
        ACCESS: begin
          if (MemAck) begin
            if (l_rd) LoadData <= ld_fmt;
            LoadValid <= l_rd;
          end else if (tmo) begin
            if (l_rd) LoadData <= '0;
            LoadValid  <= l_rd;
            MemTimeout <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register: turns the registered MemRead/MemWrite, ALU address, store data and instruction word into a req/ack data-memory transaction.
- Generates the pipeline stall while an access is pending and formats load data (lb/lbu/lh/lhu/lw) for the MEM/WB register.
- Sits between the EX/MEM register outputs and the data memory port. MemStall also freezes the EX/MEM register, so its inputs stay stable until the access finishes.

Parameters:
MAX_WAIT, 15, number of ACCESS cycles without MemAck before the access is aborted (1..255).

Ports:
Clk  in  1  clock, all state updates on posedge
Reset  in  1  synchronous, active-high reset
inMemRead  in  1  EX/MEM MemRead
inMemWrite  in  1  EX/MEM MemWrite
inALUResult  in  32  EX/MEM byte address
inReadData2  in  32  EX/MEM store data
inInstr  in  32  EX/MEM instruction; opcode [31:26] selects size and sign
MemStall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
MemReq  out  1  memory request
MemWe  out  1  1 = write, 0 = read
MemAddr  out  32  word address {addr[31:2],2'b00}
MemWData  out  32  lane-replicated store data
MemByteEn  out  4  byte-lane enables, bit i = bits [8i+7:8i]
MemAck  in  1  memory completion, one cycle
MemRData  in  32  read data, valid when MemAck=1
LoadData  out  32  formatted load result, held until the next load completes
LoadValid  out  1  one-cycle pulse when LoadData is updated
AddrError  out  1  one-cycle pulse for a misaligned access
MemTimeout  out  1  one-cycle pulse for an aborted access

Behaviour:
- Reset (synchronous, overrides everything):
  - state = IDLE, wait counter = 0.
  - MemReq, MemWe, LoadValid, AddrError, MemTimeout = 0; LoadData = 0.
  - MemAddr, MemWData, MemByteEn = 0.
  - Any in-flight request is dropped; the memory side must tolerate this.
- Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0].
- Opcode decode:
  - 0x20 lb, 0x24 lbu, 0x21 lh, 0x25 lhu, 0x23 lw.
  - 0x28 sb, 0x29 sh, 0x2B sw.
  - Any other opcode with MemRead or MemWrite set is treated as a word access.
- If MemRead and MemWrite are both 1, the write wins and the read is ignored.
- Access = inMemRead | inMemWrite.
- Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM IDLE:
  - Access and aligned: latch MemAddr, MemWe, byte enables and store data; MemStall=1 combinationally in this same cycle; next state ACCESS.
  - Access and misaligned: no request, no stall, store suppressed; AddrError=1 in the next cycle; stay IDLE.
  - Otherwise: MemStall=0.
- FSM ACCESS:
  - MemReq=1 and MemStall=1; all Mem* outputs are held stable.
  - Wait counter increments each cycle without MemAck.
  - On MemAck: if it was a read, register the formatted MemRData into LoadData; next state DONE.
  - If the counter reaches MAX_WAIT without MemAck: abort; LoadData=0 if it was a read; MemTimeout=1 in the DONE cycle; next state DONE.
- FSM DONE:
  - MemReq=0, MemStall=0 (the EX/MEM register advances at this edge).
  - LoadValid=1 only if the access was a read.
  - Next state is IDLE unconditionally, so the held instruction is never re-issued.
- Latency with a zero-wait memory (ack in the first ACCESS cycle): 3 cycles per memory op (IDLE detect, ACCESS, DONE). Each wait cycle adds 1.
- MemAck outside ACCESS is ignored. MemAck in the same cycle the counter hits MAX_WAIT counts as success.
- Store formatting:
  - sb: data[7:0] replicated to all 4 lanes; MemByteEn = 1 << addr[1:0].
  - sh: data[15:0] replicated to both halves; MemByteEn = addr[1] ? 4'b1100 : 4'b0011.
  - sw: MemByteEn = 4'b1111.
- Loads always use MemByteEn = 4'b1111.
- Load formatting: select the byte or halfword by address; lb/lh sign-extend, lbu/lhu zero-extend.

Test Plan:
1. Reset, then lw at 0x0000_0010 with memory returning 0xDEADBEEF on ack in the first ACCESS cycle -> MemStall high for 2 cycles; MemAddr=0x10, MemByteEn=4'hF; LoadValid pulse with LoadData=0xDEADBEEF in the 3rd cycle.
2. lb at 0x13 with MemRData=0x80112233 -> LoadData=0xFFFFFF80; lbu at the same address -> 0x00000080; lh at 0x12 -> 0xFFFF8011.
3. sh at 0x0000_0006 with store data 0x1234ABCD -> MemWe=1, MemAddr=0x04, MemByteEn=4'b1100, MemWData=0xABCDABCD; no LoadValid pulse.
4. sw with MemAck delayed by 3 cycles -> MemReq and all Mem* outputs stable for 4 ACCESS cycles; MemStall high for 5 cycles total; then one DONE cycle.
5. lw at 0x0000_0002 -> no MemReq, no MemStall, AddrError pulse one cycle later. Separately, lw with MemAck never asserted and MAX_WAIT=15 -> abort after 15 ACCESS cycles, MemTimeout and LoadValid pulse together, LoadData=0.
6. Reset asserted in the 2nd ACCESS cycle of a pending lw -> next cycle MemReq=0, MemStall=0, state IDLE; a late MemAck is ignored and LoadData stays 0.
